// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage word accesses into two halfword cycles on a 16-bit async SRAM.
// Latency 1 + 2*WAIT_CYCLES cycles with ready low, then one DONE cycle; ~ready freezes the pipeline.
// Optional address range checking is enabled by defining SRAM_CTRL_RANGE_CHECK_EN.
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        addr_err,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic        op_wr;
    logic [31:0] wdata;
    logic [16:0] idx;
    logic [16:0] word_idx;
    logic        req;
    logic        active;

    assign req      = wr_en | rd_en;
    assign word_idx = 17'((address - BASE_ADDR) >> 2);
    assign active   = (state == S_LO) || (state == S_HI);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic [31:0] offset;
    logic        addr_bad;
    logic        err_q;

    assign offset   = address - BASE_ADDR;
    assign addr_bad = (address < BASE_ADDR) || (address[1:0] != 2'b00) || (offset[31:19] != 13'd0);
    assign addr_err = err_q;
`else
    assign addr_err = 1'b0;
`endif

    // rst forces ready high at once so the freeze releases even while a request is held.
    assign ready       = rst || (state == S_DONE) || ((state == S_IDLE) && !req);
    assign sram_dq_oe  = active && op_wr;
    assign sram_we_n   = !(active && op_wr);
    assign sram_dq_out = (active && op_wr) ? ((state == S_HI) ? wdata[31:16] : wdata[15:0]) : 16'h0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            op_wr     <= 1'b0;
            wdata     <= 32'h0;
            idx       <= 17'd0;
            read_data <= 32'h0;
            sram_addr <= 18'd0;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef SRAM_CTRL_RANGE_CHECK_EN
            err_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req) begin
`ifdef SRAM_CTRL_RANGE_CHECK_EN
                        if (addr_bad) begin
                            state <= S_DONE;
                            err_q <= 1'b1;
                        end else
`endif
                        begin
                            op_wr     <= wr_en;
                            wdata     <= write_data;
                            idx       <= word_idx;
                            sram_addr <= {word_idx, 1'b0};
                            wait_cnt  <= 4'd0;
                            state     <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt  <= 4'd0;
                        sram_addr <= {idx, 1'b1};
                        state     <= S_HI;
                        if (!op_wr) read_data[15:0] <= sram_dq_in;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_HI: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 4'd0;
                        state    <= S_DONE;
                        if (!op_wr) read_data[31:16] <= sram_dq_in;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM model, scoreboard of expected completions, and a WAIT_CYCLES=1 instance.
module tb_sram_controller;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          low;
        int          we;
        logic [17:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = 32'h0, write_data = 32'h0;
    logic [31:0] read_data;
    logic        ready, addr_err, sram_dq_oe, sram_we_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;

    logic        wr_en1 = 1'b0;
    logic [31:0] read_data1;
    logic        ready1, addr_err1, sram_dq_oe1, sram_we_n1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1;
    logic [15:0] dq_zero = 16'h0000;
    logic        rd_zero = 1'b0;

    logic [15:0] mem [0:63];
    exp_t        exp_q[$];
    int          done_cyc[$];
    int          n_total = 0, n_pass = 0;
    int          cyc = 0, low_cnt = 0, we_cnt = 0;
    logic        prev_rdy = 1'b1;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .addr_err(addr_err),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_controller #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_zero), .address(32'd1024),
        .write_data(32'h0BADF00D), .read_data(read_data1), .ready(ready1), .addr_err(addr_err1),
        .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
        .sram_dq_in(dq_zero), .sram_we_n(sram_we_n1)
    );

    assign sram_dq_in = mem[sram_addr[5:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // SRAM model: capture the driven halfword on every strobed cycle.
    always @(negedge clk) begin
        if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
    end

    // Monitor: a completion is the first ready-high cycle after a ready-low stretch.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            prev_rdy = 1'b1;
            low_cnt  = 0;
            we_cnt   = 0;
        end else begin
            if (!ready) low_cnt++;
            if (!sram_we_n) we_cnt++;
            if (ready && !prev_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", read_data, e.rd);
                    check("addr_err", {31'd0, addr_err}, {31'd0, e.err});
                    check("ready_low_cycles", low_cnt, e.low);
                    check("we_low_cycles", we_cnt, e.we);
                    check("sram_addr_done", {14'd0, sram_addr}, {14'd0, e.addr});
                end
                done_cyc.push_back(cyc);
                low_cnt = 0;
                we_cnt  = 0;
            end
            prev_rdy = ready;
        end
    end

    task automatic expect_done(input logic [31:0] rd, input logic err, input int low, input int we,
                               input logic [17:0] addr);
        exp_t e;
        e.rd = rd; e.err = err; e.low = low; e.we = we; e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            check("completion_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        int low1, we1;
        bit seen;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_read_data", read_data, 32'h0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);

        // Write then read back
        expect_done(32'h0, 1'b0, 5, 4, 18'd5);
        issue(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
        drain();
        check("mem4", {16'd0, mem[4]}, 32'h0000BEEF);
        check("mem5", {16'd0, mem[5]}, 32'h0000DEAD);
        expect_done(32'hDEADBEEF, 1'b0, 5, 0, 18'd5);
        issue(1'b0, 1'b1, 32'd1032, 32'h0);
        drain();

        // Back-to-back reads with rd_en held
        expect_done(32'h22221111, 1'b0, 5, 0, 18'd1);
        expect_done(32'h44443333, 1'b0, 5, 0, 18'd3);
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'd1024;
        @(posedge clk); #1;
        address = 32'd1028;
        repeat (6) @(posedge clk);
        #1 rd_en = 1'b0;
        drain();
        if (done_cyc.size() >= 2)
            check("b2b_gap", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 6);
        else
            check("b2b_completions", done_cyc.size(), 2);

        // Both enables: write wins, read_data kept
        expect_done(32'h44443333, 1'b0, 5, 4, 18'd9);
        issue(1'b1, 1'b1, 32'd1040, 32'h12345678);
        drain();
        check("mem8", {16'd0, mem[8]}, 32'h00005678);
        check("mem9", {16'd0, mem[9]}, 32'h00001234);

        // Reset during the HI phase of a write
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1048; write_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        wr_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sram_addr == 18'd13 && !sram_we_n) begin
                seen = 1'b1;
                break;
            end
        end
        check("reached_hi_phase", {31'd0, seen}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("midrst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        expect_done(32'hCAFEF00D, 1'b0, 5, 0, 18'd13);
        issue(1'b0, 1'b1, 32'd1048, 32'h0);
        drain();

`ifdef SRAM_CTRL_RANGE_CHECK_EN
        expect_done(32'hCAFEF00D, 1'b1, 1, 0, 18'd13);
        issue(1'b0, 1'b1, 32'd1026, 32'h0);
        drain();
        expect_done(32'hCAFEF00D, 1'b1, 1, 0, 18'd13);
        issue(1'b0, 1'b1, 32'd1020, 32'h0);
        drain();
`else
        expect_done(32'h22221111, 1'b0, 5, 0, 18'd1);
        issue(1'b0, 1'b1, 32'd1026, 32'h0);
        drain();
`endif

        // WAIT_CYCLES=1 write on the second instance
        low1 = 0; we1 = 0; seen = 1'b0;
        @(posedge clk); #1;
        wr_en1 = 1'b1;
        #1 if (!ready1) low1++;
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ready1) low1++;
            if (!sram_we_n1) we1++;
            if (ready1) begin
                seen = 1'b1;
                break;
            end
        end
        check("w1_done_seen", {31'd0, seen}, 32'd1);
        check("w1_ready_low", low1, 3);
        check("w1_we_low", we1, 2);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences 32-bit word accesses from the MEM stage onto a 16-bit-wide external asynchronous SRAM, splitting each word into two halfword cycles with programmable wait states. Sits between the MEM stage and the SRAM pins. Its `ready` output, inverted, is the pipeline-wide freeze that holds the MEM/WB stage register and all upstream stages while an access is in flight.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: cycles spent per halfword phase; legal range 1..15.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM halfword 0.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `wr_en`  in  1  word write request from the MEM stage.
- `rd_en`  in  1  word read request from the MEM stage.
- `address`  in  32  byte address.
- `write_data`  in  32  store data.
- `read_data`  out  32  load data; valid while `ready`=1 in the DONE state; held until the next read completes.
- `ready`  out  1  1 = no access pending. Pipeline freeze = ~ready.
- `addr_err`  out  1  one-cycle pulse on a rejected access (see Configuration).
- `sram_addr`  out  18  SRAM halfword address.
- `sram_dq_out`  out  16  write data to the SRAM pins.
- `sram_dq_oe`  out  1  1 = controller drives the DQ bus.
- `sram_dq_in`  in  16  DQ bus sampled value.
- `sram_we_n`  out  1  active-low write strobe.

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE:
  - No request: `ready`=1.
  - `wr_en|rd_en`=1: `ready`=0 combinationally in the same cycle. Latch `address`, `write_data` and op (write if `wr_en`=1, otherwise read). Go to LO.
- Write wins when `wr_en` and `rd_en` are both 1. `read_data` is not updated in that case.
- Word index = (`address` - `BASE_ADDR`) >> 2, truncated to 17 bits.
- LO phase:
  - `sram_addr` = {idx, 0}.
  - Lasts `WAIT_CYCLES` cycles, counted by a 4-bit wait counter; then go to HI.
- HI phase:
  - `sram_addr` = {idx, 1}.
  - Lasts `WAIT_CYCLES` cycles; then go to DONE.
- Write phases:
  - `sram_dq_oe`=1 and `sram_we_n`=0 for every cycle of the phase.
  - `sram_dq_out` = latched data [15:0] in LO, [31:16] in HI.
- Read phases:
  - `sram_dq_oe`=0, `sram_we_n`=1.
  - `sram_dq_in` is sampled on the final cycle of LO into `read_data`[15:0] and on the final cycle of HI into `read_data`[31:16].
- DONE: `ready`=1 for exactly one cycle, then go to IDLE unconditionally.
- Requests are ignored outside IDLE. Changes to `address`, data or enables mid-access have no effect.
- In IDLE and DONE: `sram_dq_oe`=0, `sram_we_n`=1, `sram_addr` holds its last value.

## Timing
- Reset values: state IDLE, `ready`=1, `read_data`=0, `addr_err`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, wait counter 0.
- Accepted access: `ready` is low for 1 + 2·`WAIT_CYCLES` cycles, then high for 1 cycle in DONE. With default parameters: low 5 cycles, high on the 6th.
- The pipeline advances on the clock edge ending DONE. A request presented in the next IDLE cycle starts a new access with no bubble.
- Reset mid-access: outputs take reset values asynchronously. The partial SRAM write is not rolled back.

## Configuration
- `SRAM_CTRL_RANGE_CHECK_EN` defined:
  - In IDLE, an access is rejected if `address` < `BASE_ADDR`, if `address`[1:0] ≠ 0, or if (`address` - `BASE_ADDR`) ≥ 2^19.
  - A rejected access goes IDLE → DONE with `ready`=0 for 1 cycle, and `addr_err` pulses in the DONE cycle.
  - No SRAM strobes are issued and `read_data` is unchanged.
- Not defined: no checking. The address is truncated as described in Operation and `addr_err` is tied to 0.

## Test plan
- Write then read back (`WAIT_CYCLES`=2):
  - Write 0xDEADBEEF to address 1032 → `sram_addr` 4 is written with 0xBEEF and `sram_addr` 5 with 0xDEAD; `ready` is low 5 cycles, then high 1 cycle.
  - Read of address 1032, with the SRAM model returning those values → `read_data`=0xDEADBEEF in DONE.
- Back-to-back reads at 1024 and 1028 with requests held high → two complete 6-cycle windows, no idle cycle between them, and `sram_addr` sequence 0, 1, 2, 3.
- `wr_en`=`rd_en`=1 with data 0x12345678 → a write is performed and `read_data` retains its previous value.
- Assert `rst` during the HI phase of a write → `ready`=1, `sram_we_n`=1 and `sram_dq_oe`=0 immediately. The next request completes normally.
- With the macro defined, read of address 1026 or 1020 → `ready` low 1 cycle, `addr_err` pulses once, no `sram_we_n` activity, `read_data` unchanged. Without the macro, the same read of 1026 performs a normal read of halfwords 0 and 1.
- `WAIT_CYCLES`=1 write → `sram_we_n` low for exactly 2 cycles in total, and `ready` low for 3 cycles.
